// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code parser for the Tetris controls: tracks E0/F0/E1 prefixes,
// keeps a pressed-key bitmap and queues make/break events in a small FIFO.
module ps2_key_decoder #(
   parameter int TIMEOUT_BITS = 20,
   parameter int FIFO_AW      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_rddata_valid,
   input  logic [7:0] ps2_rd_data,
   output logic       key_evt_valid,
   input  logic       key_evt_ready,
   output logic [2:0] key_evt_code,
   output logic       key_evt_make,
   output logic [7:0] key_state,
   output logic       key_ovf,
   input  logic       ovf_clr
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [TIMEOUT_BITS-1:0] TO_ONES = {TIMEOUT_BITS{1'b1}};
   localparam logic [TIMEOUT_BITS-1:0] TO_ONE  = 1;
   localparam logic [FIFO_AW:0]        PTR_ONE = 1;

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK,
      SKIP
   } state_t;

   state_t                    state_q, state_d;
   logic [2:0]                skip_q, skip_d;
   logic [TIMEOUT_BITS-1:0]   to_cnt_q, to_cnt_d;
   logic [7:0]                key_state_q, key_state_d;
   logic                      key_ovf_q, key_ovf_d;
   logic [FIFO_AW:0]          wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0]          rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0][3:0]     mem_q, mem_d;

   logic       is_ext, is_brk;
   logic       dec_hit;
   logic [2:0] dec_code;
   logic       push;
   logic [3:0] push_data;
   logic       fifo_empty, fifo_full, pop, wr, drop;

   function automatic logic is_status(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_status = 1'b1;
         default:                                                 is_status = 1'b0;
      endcase
   endfunction

   // Returns {hit, code}; unprefixed arrow codes are keypad keys and stay unmapped.
   function automatic logic [3:0] decode(input logic [7:0] b, input logic ext);
      decode = 4'b0000;
      if (ext) begin
         case (b)
            8'h6B:   decode = {1'b1, 3'd0};
            8'h74:   decode = {1'b1, 3'd1};
            8'h72:   decode = {1'b1, 3'd2};
            8'h75:   decode = {1'b1, 3'd3};
            8'h5A:   decode = {1'b1, 3'd5};
            default: decode = 4'b0000;
         endcase
      end else begin
         case (b)
            8'h29:   decode = {1'b1, 3'd4};
            8'h5A:   decode = {1'b1, 3'd5};
            8'h76:   decode = {1'b1, 3'd6};
            8'h4D:   decode = {1'b1, 3'd7};
            default: decode = 4'b0000;
         endcase
      end
   endfunction

   always_comb begin
      state_d     = state_q;
      skip_d      = skip_q;
      to_cnt_d    = to_cnt_q;
      key_state_d = key_state_q;
      is_ext      = (state_q == EXT) || (state_q == EXT_BRK);
      is_brk      = (state_q == BRK) || (state_q == EXT_BRK);
      dec_hit     = 1'b0;
      dec_code    = 3'd0;
      push        = 1'b0;
      push_data   = 4'b0000;

      if (ps2_rddata_valid) begin
         if (state_q == SKIP) begin
            // Every byte of the pause sequence, including its second E1, is swallowed.
            skip_d = skip_q - 3'd1;
            if (skip_q <= 3'd1) begin
               state_d  = IDLE;
               skip_d   = 3'd0;
               to_cnt_d = '0;
            end else begin
               to_cnt_d = TO_ONES;
            end
         end else if (ps2_rd_data == 8'hE1) begin
            state_d  = SKIP;
            skip_d   = 3'd7;
            to_cnt_d = TO_ONES;
         end else if (ps2_rd_data == 8'hE0) begin
            state_d  = is_brk ? EXT_BRK : EXT;
            to_cnt_d = TO_ONES;
         end else if (ps2_rd_data == 8'hF0) begin
            state_d  = is_ext ? EXT_BRK : BRK;
            to_cnt_d = TO_ONES;
         end else if ((state_q == IDLE) && is_status(ps2_rd_data)) begin
            state_d = IDLE;
         end else begin
            {dec_hit, dec_code} = decode(ps2_rd_data, is_ext);
            state_d  = IDLE;
            to_cnt_d = '0;
         end
      end else if (state_q != IDLE) begin
         if (to_cnt_q <= TO_ONE) begin
            state_d  = IDLE;
            skip_d   = 3'd0;
            to_cnt_d = '0;
         end else begin
            to_cnt_d = to_cnt_q - TO_ONE;
         end
      end

      // Typematic repeats and releases of unpressed keys produce no event.
      if (dec_hit) begin
         if (!is_brk && !key_state_q[dec_code]) begin
            key_state_d[dec_code] = 1'b1;
            push      = 1'b1;
            push_data = {1'b1, dec_code};
         end else if (is_brk && key_state_q[dec_code]) begin
            key_state_d[dec_code] = 1'b0;
            push      = 1'b1;
            push_data = {1'b0, dec_code};
         end
      end
   end

   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
      pop        = !fifo_empty && key_evt_ready;
      wr         = push && (!fifo_full || pop);
      drop       = push && fifo_full && !pop;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (wr) begin
         mem_d[wr_ptr_q[FIFO_AW-1:0]] = push_data;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
         key_ovf_d = 1'b1;
      end else if (ovf_clr) begin
         key_ovf_d = 1'b0;
      end else begin
         key_ovf_d = key_ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         skip_q      <= 3'd0;
         to_cnt_q    <= '0;
         key_state_q <= 8'h00;
         key_ovf_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_q       <= '0;
      end else begin
         state_q     <= state_d;
         skip_q      <= skip_d;
         to_cnt_q    <= to_cnt_d;
         key_state_q <= key_state_d;
         key_ovf_q   <= key_ovf_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_q       <= mem_d;
      end
   end

   assign key_evt_valid = !fifo_empty;
   assign key_evt_code  = mem_q[rd_ptr_q[FIFO_AW-1:0]][2:0];
   assign key_evt_make  = mem_q[rd_ptr_q[FIFO_AW-1:0]][3];
   assign key_state     = key_state_q;
   assign key_ovf       = key_ovf_q;

endmodule
